// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer.
//   NB_LANES   : byte lanes per data word
//   MASK_*     : access-size codes as carried by the pipeline (10 also means word)
//   state_t    : sequencer state encoding
//   is_misaligned() : alignment rule for a size code and the low address bits
package mips_mem_pkg;

  localparam int NB_LANES = 4;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Any code with bit 1 set is a word access.
  function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] lane);
    if (mask[1])           return lane != 2'b00;
    else if (mask == MASK_HALF) return lane[0];
    else                   return 1'b0;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge data-memory port.
//   req    : request, held until ack
//   we     : write qualifier (valid with req)
//   addr   : word-aligned byte address
//   wdata  : lane-replicated store data
//   be     : byte enables
//   ack    : request accepted
//   rvalid : read data valid
//   rdata  : read data word
// master = access controller, slave = memory.
interface mem_access_ctrl_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32
);
  logic               req;
  logic               we;
  logic [NB_ADDR-1:0] addr;
  logic [NB_DATA-1:0] wdata;
  logic [3:0]         be;
  logic               ack;
  logic               rvalid;
  logic [NB_DATA-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rvalid, rdata);
endinterface

// File: rtl/mem_access_ctrl_load_aligner.sv
// load_aligner: selects the addressed byte/half of a read word and sign- or
// zero-extends it; word accesses pass straight through.
//   i_rdata       : raw memory word
//   i_lane        : addr[1:0] of the access
//   i_mascara     : size code
//   i_is_unsigned : zero-extend instead of sign-extend (ignored for words)
//   o_data        : extended result
module load_aligner
  import mips_mem_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] i_rdata,
  input  logic [1:0]         i_lane,
  input  logic [1:0]         i_mascara,
  input  logic               i_is_unsigned,
  output logic [NB_DATA-1:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halves are only ever on lane 0 or 2 (odd lanes fault earlier).
  assign byte_sel = i_rdata[{i_lane, 3'b000} +: 8];
  assign half_sel = i_rdata[{i_lane[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_rdata;
    if (i_mascara == MASK_BYTE)
      o_data = {{(NB_DATA-8){byte_sel[7] & ~i_is_unsigned}}, byte_sel};
    else if (i_mascara == MASK_HALF)
      o_data = {{(NB_DATA-16){half_sel[15] & ~i_is_unsigned}}, half_sel};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer.
// Takes one byte/half/word access from the pipeline, checks alignment, runs a
// req/ack memory transaction with byte enables, lane-aligns and extends load
// data, and stalls the pipeline (o_busy) until done, faulted or timed out.
//   i_clock, i_reset (async, active low)
//   pipeline side : i_valid, i_is_load, i_addr, i_wdata, i_mascara, i_is_unsigned
//                   o_busy, o_done, o_rdata, o_misaligned, o_timeout
//   mem           : memory port (master side)
// All outputs come from registers or the state decode only.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32,
  parameter int NB_MASK = 2,
  parameter int TIMEOUT = 16,
  parameter int NB_TMO  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_is_load,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_MASK-1:0] i_mascara,
  input  logic               i_is_unsigned,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_rdata,
  output logic               o_misaligned,
  output logic               o_timeout,
  mem_access_ctrl_if.master  mem
);

  localparam logic [NB_TMO-1:0] TMO_LAST = NB_TMO'(TIMEOUT - 1);

  state_t             state, state_n;
  logic [NB_TMO-1:0]  cnt;
  logic               fault_tmo;
  logic [NB_ADDR-1:0] lat_addr;
  logic [NB_DATA-1:0] lat_wdata;
  logic [1:0]         lat_mask;
  logic               lat_uns;
  logic               lat_load;
  logic               tmo_hit;
  logic [3:0]         be;
  logic [NB_DATA-1:0] wdata_rep;
  logic [NB_DATA-1:0] ld_data;

  // >= rather than ==: a load acked on the last counted cycle enters WAIT
  // with the counter already past TIMEOUT-1 and must still be bounded.
  assign tmo_hit = (cnt >= TMO_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (i_valid)
                 state_n = is_misaligned(i_mascara[1:0], i_addr[1:0]) ? ST_ERR : ST_REQ;
      ST_REQ:  if (mem.ack)     state_n = lat_load ? ST_WAIT : ST_DONE;
               else if (tmo_hit) state_n = ST_ERR;
      ST_WAIT: if (mem.rvalid)  state_n = ST_DONE;
               else if (tmo_hit) state_n = ST_ERR;
      ST_DONE: state_n = ST_IDLE;
      ST_ERR:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Request latch, timeout counter, fault cause and load result.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_mask  <= '0;
      lat_uns   <= 1'b0;
      lat_load  <= 1'b0;
      cnt       <= '0;
      fault_tmo <= 1'b0;
      o_rdata   <= '0;
    end else begin
      if (state == ST_IDLE && i_valid) begin
        lat_addr  <= i_addr;
        lat_wdata <= i_wdata;
        lat_mask  <= i_mascara[1:0];
        lat_uns   <= i_is_unsigned;
        lat_load  <= i_is_load;
        cnt       <= '0;
        fault_tmo <= 1'b0;
      end
      if (state == ST_REQ || state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
        if (state_n == ST_ERR) fault_tmo <= 1'b1;
      end
      if (state == ST_WAIT && mem.rvalid) o_rdata <= ld_data;
    end
  end

  load_aligner #(.NB_DATA(NB_DATA)) u_aligner (
    .i_rdata       (mem.rdata),
    .i_lane        (lat_addr[1:0]),
    .i_mascara     (lat_mask),
    .i_is_unsigned (lat_uns),
    .o_data        (ld_data)
  );

  // Store encoding: replicate data across lanes, enable only the target bytes.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = lat_wdata;
    if (!lat_load) begin
      if (lat_mask == MASK_BYTE) begin
        be        = 4'b0001 << lat_addr[1:0];
        wdata_rep = {NB_LANES{lat_wdata[7:0]}};
      end else if (lat_mask == MASK_HALF) begin
        be        = 4'b0011 << lat_addr[1:0];
        wdata_rep = {(NB_LANES/2){lat_wdata[15:0]}};
      end
    end
  end

  // Bus fields are only driven during REQ so the port idles at zero.
  assign mem.req   = (state == ST_REQ);
  assign mem.we    = mem.req & ~lat_load;
  assign mem.addr  = mem.req ? {lat_addr[NB_ADDR-1:2], 2'b00} : '0;
  assign mem.be    = mem.req ? be : 4'b0000;
  assign mem.wdata = mem.req ? wdata_rep : '0;

  assign o_busy       = (state != ST_IDLE);
  assign o_done       = (state == ST_DONE);
  assign o_misaligned = (state == ST_ERR) & ~fault_tmo;
  assign o_timeout    = (state == ST_ERR) &  fault_tmo;

endmodule
